// File: rtl/contador_ctrl_if.sv
// rtl/contador_ctrl_if.sv - control/status bundle between front panel and contador_ctrl
interface contador_ctrl_if;
    logic        sel;
    logic [15:0] tempo;
    logic        start;
    logic        pause;
    logic        clear;
    logic        lap;
    logic [15:0] segundos;
    logic [15:0] lap_segundos;
    logic        running;
    logic        done;
    logic        tick;

    modport master (
        output sel, tempo, start, pause, clear, lap,
        input  segundos, lap_segundos, running, done, tick
    );

    modport slave (
        input  sel, tempo, start, pause, clear, lap,
        output segundos, lap_segundos, running, done, tick
    );
endinterface

// File: rtl/contador_ctrl.sv
// rtl/contador_ctrl.sv - stopwatch/timer seconds counter with pause, clear and lap capture
// Optional lap capture is enabled with `define LAP_EN.
module contador_ctrl #(
    parameter int CLKS_PER_SEC = 50000000
) (
    input  logic           clk,
    input  logic           rst_n,
    contador_ctrl_if.slave bus
);

    localparam logic [25:0] PRESC_LAST = 26'(CLKS_PER_SEC - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

    state_t      state, state_n;
    logic [25:0] presc, presc_n;
    logic [15:0] seg, seg_n;
    logic [15:0] lap_q, lap_n;
    logic [15:0] tempo_q, tempo_n;
    logic        mode_q, mode_n;
    logic        tick_q, tick_n;
    logic        running_q, done_q;
    logic        start_p, pause_p, clear_p, lap_p;

    logic        ev_start, ev_pause, ev_clear, ev_lap;
    logic [15:0] idle_load, term, seg_step;

    assign ev_start = bus.start & ~start_p;
    assign ev_pause = bus.pause & ~pause_p;
    assign ev_clear = bus.clear & ~clear_p;
    assign ev_lap   = bus.lap   & ~lap_p;

    assign idle_load = bus.sel ? bus.tempo : 16'd0;
    assign term      = mode_q ? 16'd0 : tempo_q;

    // Saturating step keeps segundos from wrapping at either end.
    always_comb begin
        seg_step = seg;
        if (mode_q) begin
            if (seg != 16'd0) seg_step = seg - 16'd1;
        end else begin
            if (seg != 16'hFFFF) seg_step = seg + 16'd1;
        end
    end

    always_comb begin
        state_n = state;
        presc_n = presc;
        seg_n   = seg;
        lap_n   = lap_q;
        tempo_n = tempo_q;
        mode_n  = mode_q;
        tick_n  = 1'b0;

        if (ev_clear) begin
            state_n = IDLE;
            presc_n = 26'd0;
`ifdef LAP_EN
            lap_n   = 16'd0;
`endif
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (state == IDLE) seg_n = idle_load;
                    if (ev_start) begin
                        mode_n  = bus.sel;
                        tempo_n = bus.tempo;
                        seg_n   = idle_load;
                        presc_n = 26'd0;
                        state_n = RUN;
                    end
                end
                RUN: begin
                    // A start value already at terminal finishes without ticking.
                    if (seg == term) begin
                        state_n = DONE;
                    end else if (presc == PRESC_LAST) begin
                        presc_n = 26'd0;
                        tick_n  = 1'b1;
                        seg_n   = seg_step;
                        if (seg_step == term)
                            state_n = DONE;
                        else if (ev_pause)
                            state_n = PAUSED;
                    end else if (ev_pause) begin
                        state_n = PAUSED;
                    end else begin
                        presc_n = presc + 26'd1;
                    end
                end
                PAUSED: begin
                    if (ev_start) state_n = RUN;
                end
                default: state_n = IDLE;
            endcase
`ifdef LAP_EN
            if (ev_lap && (state == RUN || state == PAUSED))
                lap_n = seg;
`endif
        end
    end

`ifndef LAP_EN
    logic lap_unused;
    assign lap_unused = ev_lap;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            presc     <= 26'd0;
            seg       <= 16'd0;
            lap_q     <= 16'd0;
            tempo_q   <= 16'd0;
            mode_q    <= 1'b0;
            tick_q    <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            start_p   <= 1'b1;
            pause_p   <= 1'b1;
            clear_p   <= 1'b1;
            lap_p     <= 1'b1;
        end else begin
            state     <= state_n;
            presc     <= presc_n;
            seg       <= seg_n;
            lap_q     <= lap_n;
            tempo_q   <= tempo_n;
            mode_q    <= mode_n;
            tick_q    <= tick_n;
            running_q <= (state_n == RUN);
            done_q    <= (state_n == DONE);
            start_p   <= bus.start;
            pause_p   <= bus.pause;
            clear_p   <= bus.clear;
            lap_p     <= bus.lap;
        end
    end

    assign bus.segundos     = seg;
    assign bus.lap_segundos = lap_q;
    assign bus.running      = running_q;
    assign bus.done         = done_q;
    assign bus.tick         = tick_q;

endmodule

// File: tb/tb_contador_ctrl.sv
// tb/tb_contador_ctrl.sv - directed scenarios and randomized run against a behavioural model
module tb_contador_ctrl;
    localparam int CPS = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    contador_ctrl_if bus();

    contador_ctrl #(.CLKS_PER_SEC(CPS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: state 0 idle, 1 counting, 2 paused, 3 finished; phase = cycles into current second.
    int m_state, m_phase, m_sec, m_lap, m_target;
    bit m_tick;
    bit ps, pp, pc, pl;

    always @(posedge clk) begin
        bit es, ep, ec, el;
        int old_state, old_sec;
        if (!rst_n) begin
            m_state = 0; m_phase = 0; m_sec = 0; m_lap = 0; m_target = 0; m_tick = 0;
            ps = 1; pp = 1; pc = 1; pl = 1;
        end else begin
            es = bus.start && !ps; ep = bus.pause && !pp;
            ec = bus.clear && !pc; el = bus.lap && !pl;
            ps = bus.start; pp = bus.pause; pc = bus.clear; pl = bus.lap;
            old_state = m_state; old_sec = m_sec;
            m_tick = 0;
            if (ec) begin
                m_state = 0; m_phase = 0;
`ifdef LAP_EN
                m_lap = 0;
`endif
            end else begin
                if (m_state == 0) m_sec = bus.sel ? int'(bus.tempo) : 0;
                if ((m_state == 0 || m_state == 3) && es) begin
                    m_sec    = bus.sel ? int'(bus.tempo) : 0;
                    m_target = bus.sel ? 0 : int'(bus.tempo);
                    m_phase  = 0;
                    m_state  = 1;
                end else if (m_state == 1) begin
                    if (m_sec == m_target) m_state = 3;
                    else if (m_phase == CPS - 1) begin
                        m_phase = 0; m_tick = 1;
                        m_sec = (m_target == 0) ? m_sec - 1 : m_sec + 1;
                        if (m_sec == m_target) m_state = 3;
                        else if (ep) m_state = 2;
                    end else if (ep) m_state = 2;
                    else m_phase = m_phase + 1;
                end else if (m_state == 2 && es) begin
                    m_state = 1;
                end
`ifdef LAP_EN
                if (el && (old_state == 1 || old_state == 2)) m_lap = old_sec;
`endif
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 0; bus.start = 1; bus.pause = 0; bus.clear = 0; bus.lap = 0;
        bus.sel = 1; bus.tempo = 16'd7;
        cyc(2);
        n_checks++; if (bus.segundos !== 16'd0) begin n_fail++; $display("FAIL reset_segundos: got %0d expected 0", bus.segundos); end
        n_checks++; if (bus.lap_segundos !== 16'd0) begin n_fail++; $display("FAIL reset_lap: got %0d expected 0", bus.lap_segundos); end
        n_checks++; if (bus.running !== 1'b0) begin n_fail++; $display("FAIL reset_running: got %b expected 0", bus.running); end
        n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        n_checks++; if (bus.tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %b expected 0", bus.tick); end
        rst_n = 1;
        cyc(2);
        n_checks++; if (bus.running !== 1'b0) begin n_fail++; $display("FAIL reset_held_start: running got %b expected 0", bus.running); end
        n_checks++; if (bus.segundos !== 16'd7) begin n_fail++; $display("FAIL idle_load_timer: got %0d expected 7", bus.segundos); end
        bus.start = 0;
        cyc(1);
    endtask

    task automatic test_stopwatch;
        int bad;
        bus.sel = 0; bus.tempo = 16'd3;
        cyc(1);
        bus.start = 1; cyc(1); bus.start = 0;
        for (int n = 0; n <= 12; n++) begin
            bit et;
            et = (n > 0 && n % 4 == 0);
            n_checks++; if (bus.tick !== et) begin n_fail++; $display("FAIL sw_tick n=%0d: got %b expected %b", n, bus.tick, et); end
            if (et) begin
                n_checks++; if (bus.segundos !== 16'(n / 4)) begin n_fail++; $display("FAIL sw_value n=%0d: got %0d expected %0d", n, bus.segundos, n / 4); end
            end
            if (n < 12) cyc(1);
        end
        n_checks++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL sw_done: got %b expected 1", bus.done); end
        n_checks++; if (bus.running !== 1'b0) begin n_fail++; $display("FAIL sw_running: got %b expected 0", bus.running); end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            if (bus.segundos !== 16'd3 || bus.tick !== 1'b0) bad++;
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL sw_hold: %0d bad cycles expected 0", bad); end
    endtask

    task automatic test_timer;
        bus.clear = 1; cyc(1); bus.clear = 0;
        bus.sel = 1; bus.tempo = 16'd2;
        cyc(2);
        n_checks++; if (bus.segundos !== 16'd2) begin n_fail++; $display("FAIL tm_idle: got %0d expected 2", bus.segundos); end
        bus.start = 1; cyc(1); bus.start = 0;
        for (int n = 0; n <= 8; n++) begin
            bit et;
            et = (n == 4 || n == 8);
            n_checks++; if (bus.tick !== et) begin n_fail++; $display("FAIL tm_tick n=%0d: got %b expected %b", n, bus.tick, et); end
            if (n == 4) begin
                n_checks++; if (bus.segundos !== 16'd1) begin n_fail++; $display("FAIL tm_value1: got %0d expected 1", bus.segundos); end
            end
            if (n < 8) cyc(1);
        end
        n_checks++; if (bus.segundos !== 16'd0) begin n_fail++; $display("FAIL tm_value0: got %0d expected 0", bus.segundos); end
        n_checks++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL tm_done: got %b expected 1", bus.done); end
        bus.tempo = 16'd0;
        bus.start = 1; cyc(1); bus.start = 0;
        n_checks++; if (bus.running !== 1'b1 || bus.done !== 1'b0) begin n_fail++; $display("FAIL tm0_run: running %b done %b expected 1 0", bus.running, bus.done); end
        cyc(1);
        n_checks++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL tm0_done: got %b expected 1", bus.done); end
        n_checks++; if (bus.tick !== 1'b0) begin n_fail++; $display("FAIL tm0_tick: got %b expected 0", bus.tick); end
    endtask

    task automatic test_pause_resume;
        int bad;
        bus.clear = 1; cyc(1); bus.clear = 0;
        bus.sel = 1; bus.tempo = 16'd5;
        cyc(1);
        bus.start = 1; cyc(1); bus.start = 0;
        cyc(4);
        n_checks++; if (bus.tick !== 1'b1 || bus.segundos !== 16'd4) begin n_fail++; $display("FAIL pr_first: tick %b seg %0d expected 1 4", bus.tick, bus.segundos); end
        cyc(2);
        bus.pause = 1; cyc(1); bus.pause = 0;
        n_checks++; if (bus.running !== 1'b0) begin n_fail++; $display("FAIL pr_paused: running %b expected 0", bus.running); end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            if (bus.segundos !== 16'd4 || bus.tick !== 1'b0 || bus.running !== 1'b0) bad++;
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL pr_frozen: %0d bad cycles expected 0", bad); end
        bus.start = 1; cyc(1); bus.start = 0;
        n_checks++; if (bus.running !== 1'b1 || bus.tick !== 1'b0) begin n_fail++; $display("FAIL pr_resume: running %b tick %b expected 1 0", bus.running, bus.tick); end
        cyc(1);
        n_checks++; if (bus.tick !== 1'b0) begin n_fail++; $display("FAIL pr_early_tick: got %b expected 0", bus.tick); end
        cyc(1);
        n_checks++; if (bus.tick !== 1'b1 || bus.segundos !== 16'd3) begin n_fail++; $display("FAIL pr_next: tick %b seg %0d expected 1 3", bus.tick, bus.segundos); end
    endtask

    task automatic test_coincidence;
        cyc(3);
        bus.pause = 1; cyc(1); bus.pause = 0;
        n_checks++; if (bus.tick !== 1'b1 || bus.segundos !== 16'd2) begin n_fail++; $display("FAIL co_tick: tick %b seg %0d expected 1 2", bus.tick, bus.segundos); end
        n_checks++; if (bus.running !== 1'b0 || bus.done !== 1'b0) begin n_fail++; $display("FAIL co_state: running %b done %b expected 0 0", bus.running, bus.done); end
        cyc(1);
        n_checks++; if (bus.segundos !== 16'd2) begin n_fail++; $display("FAIL co_frozen: got %0d expected 2", bus.segundos); end
        bus.clear = 1; bus.pause = 1; bus.start = 1;
        cyc(1);
        bus.clear = 0; bus.pause = 0; bus.start = 0;
        n_checks++; if (bus.running !== 1'b0 || bus.done !== 1'b0) begin n_fail++; $display("FAIL prio_idle: running %b done %b expected 0 0", bus.running, bus.done); end
        cyc(1);
        n_checks++; if (bus.segundos !== 16'd5) begin n_fail++; $display("FAIL prio_load: got %0d expected 5", bus.segundos); end
        bus.start = 1; cyc(1); bus.start = 0;
        cyc(3);
        n_checks++; if (bus.tick !== 1'b0) begin n_fail++; $display("FAIL prio_presc_early: got %b expected 0", bus.tick); end
        cyc(1);
        n_checks++; if (bus.tick !== 1'b1 || bus.segundos !== 16'd4) begin n_fail++; $display("FAIL prio_presc: tick %b seg %0d expected 1 4", bus.tick, bus.segundos); end
    endtask

    task automatic test_reset_midrun;
        bus.clear = 1; cyc(1); bus.clear = 0;
        bus.sel = 0; bus.tempo = 16'd100;
        bus.start = 1;
        cyc(6);
        n_checks++; if (bus.running !== 1'b1 || bus.segundos !== 16'd1) begin n_fail++; $display("FAIL mr_run: running %b seg %0d expected 1 1", bus.running, bus.segundos); end
        rst_n = 0; cyc(1);
        n_checks++; if (bus.running !== 1'b0 || bus.done !== 1'b0 || bus.tick !== 1'b0) begin n_fail++; $display("FAIL mr_flags: running %b done %b tick %b expected 0 0 0", bus.running, bus.done, bus.tick); end
        n_checks++; if (bus.segundos !== 16'd0 || bus.lap_segundos !== 16'd0) begin n_fail++; $display("FAIL mr_values: seg %0d lap %0d expected 0 0", bus.segundos, bus.lap_segundos); end
        rst_n = 1; cyc(4);
        n_checks++; if (bus.running !== 1'b0) begin n_fail++; $display("FAIL mr_no_restart: running %b expected 0", bus.running); end
        bus.start = 0; cyc(1);
        bus.start = 1; cyc(1); bus.start = 0;
        n_checks++; if (bus.running !== 1'b1) begin n_fail++; $display("FAIL mr_restart: running %b expected 1", bus.running); end
    endtask

    task automatic test_lap;
        bus.clear = 1; cyc(1); bus.clear = 0;
        bus.sel = 0; bus.tempo = 16'd10;
        cyc(1);
        bus.start = 1; cyc(1); bus.start = 0;
        cyc(8);
        n_checks++; if (bus.segundos !== 16'd2) begin n_fail++; $display("FAIL lap_pre: seg %0d expected 2", bus.segundos); end
        bus.lap = 1; cyc(1); bus.lap = 0;
`ifdef LAP_EN
        n_checks++; if (bus.lap_segundos !== 16'd2) begin n_fail++; $display("FAIL lap_capture: got %0d expected 2", bus.lap_segundos); end
        cyc(6);
        n_checks++; if (bus.lap_segundos !== 16'd2) begin n_fail++; $display("FAIL lap_hold: got %0d expected 2", bus.lap_segundos); end
        bus.clear = 1; cyc(1); bus.clear = 0;
        n_checks++; if (bus.lap_segundos !== 16'd0) begin n_fail++; $display("FAIL lap_clear: got %0d expected 0", bus.lap_segundos); end
`else
        n_checks++; if (bus.lap_segundos !== 16'd0) begin n_fail++; $display("FAIL lap_disabled: got %0d expected 0", bus.lap_segundos); end
        cyc(6);
        bus.lap = 1; cyc(1); bus.lap = 0;
        bus.clear = 1; cyc(1); bus.clear = 0;
`endif
        bus.lap = 1; cyc(1); bus.lap = 0;
        n_checks++; if (bus.lap_segundos !== 16'd0) begin n_fail++; $display("FAIL lap_idle: got %0d expected 0", bus.lap_segundos); end
    endtask

    task automatic test_random;
        int bad;
        bad = 0;
        for (int i = 0; i < 4000; i++) begin
            rst_n     = ($urandom_range(0, 299) != 0);
            bus.start = ($urandom_range(0, 5) == 0);
            bus.pause = ($urandom_range(0, 9) == 0);
            bus.clear = ($urandom_range(0, 49) == 0);
            bus.lap   = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 15) == 0) bus.sel = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) bus.tempo = 16'($urandom_range(0, 6));
            cyc(1);
            n_checks++;
            if (bus.segundos !== 16'(m_sec) || bus.lap_segundos !== 16'(m_lap) || bus.tick !== m_tick ||
                bus.running !== (m_state == 1) || bus.done !== (m_state == 3)) begin
                n_fail++; bad++;
                if (bad <= 10)
                    $display("FAIL rand_cycle %0d: seg %0d lap %0d tick %b run %b done %b expected %0d %0d %b %b %b",
                             i, bus.segundos, bus.lap_segundos, bus.tick, bus.running, bus.done,
                             m_sec, m_lap, m_tick, m_state == 1, m_state == 3);
            end
        end
        rst_n = 1;
    endtask

    initial begin
        test_reset;
        test_stopwatch;
        test_timer;
        test_pause_resume;
        test_coincidence;
        test_reset_midrun;
        test_lap;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
